// File: rtl/multicycle_sequencer_if.sv
// Shared memory-port handshake between the multicycle sequencer and the memory arbiter/datapath.
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_data;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_is_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_is_data,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the non-pipelined LEGv8 core.
// Optional memory-wait timeout fault enabled by defining SEQ_MEM_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          halt_req,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic                          reg_write,
  input  logic                          update_sreg,
  input  logic [2:0]                    branch_op,
  multicycle_sequencer_if.master        mem,
  output logic                          ir_load,
  output logic                          sreg_write_en,
  output logic                          branch_eval,
  output logic                          rf_write_en,
  output logic                          pc_write,
  output logic [2:0]                    state,
  output logic                          busy,
  output logic [31:0]                   retire_count,
  output logic                          mem_fault
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       update_sreg;
    logic [2:0] branch_op;
  } ctl_t;

  state_e             state_q;
  state_e             state_d;
  ctl_t               ctl_q;
  ctl_t               ctl_in_c;
  logic               retire_c;
  logic               timeout_c;
  logic [CNT_W-1:0]   retire_count_q;

  assign ctl_in_c = '{mem_read:    mem_read,
                      mem_write:   mem_write,
                      reg_write:   reg_write,
                      update_sreg: update_sreg,
                      branch_op:   branch_op};

  // Only the memory-phase bits are consumed after EXECUTE; the rest are kept for debug visibility.
  logic unused_ctl_c;
  assign unused_ctl_c = ^{ctl_q.reg_write, ctl_q.update_sreg, ctl_q.branch_op};

  // Next-state and strobe decode; ir_load and MEMORY retirement are qualified by mem_ack.
  always_comb begin
    state_d         = state_q;
    retire_c        = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_is_data = 1'b0;
    ir_load         = 1'b0;
    sreg_write_en   = 1'b0;
    branch_eval     = 1'b0;
    rf_write_en     = 1'b0;
    pc_write        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (timeout_c) begin
          state_d = S_HALT;
        end else if (mem.mem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        sreg_write_en = ctl_in_c.update_sreg;
        branch_eval   = |ctl_in_c.branch_op;
        if (ctl_in_c.mem_read || ctl_in_c.mem_write) begin
          state_d = S_MEMORY;
        end else if (ctl_in_c.reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          retire_c = 1'b1;
        end
      end
      S_MEMORY: begin
        mem.mem_req     = 1'b1;
        mem.mem_is_data = 1'b1;
        mem.mem_we      = ctl_q.mem_write;
        if (timeout_c) begin
          state_d = S_HALT;
        end else if (mem.mem_ack) begin
          if (ctl_q.mem_read) state_d = S_WRITEBACK;
          else                retire_c = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_write_en = 1'b1;
        retire_c    = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retirement: halt wins over run.
    if (retire_c) begin
      pc_write = 1'b1;
      if (halt_req)  state_d = S_HALT;
      else if (!run) state_d = S_IDLE;
      else           state_d = S_FETCH;
    end
  end

  // State, latched control bits and retirement counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ctl_q          <= '0;
      retire_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXECUTE) ctl_q <= ctl_in_c;
      if (retire_c) retire_count_q <= retire_count_q + CNT_W'(1);
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  logic [WAIT_W-1:0] wait_cnt_q;
  logic              waiting_c;
  logic              mem_fault_q;

  assign waiting_c = mem.mem_req && !mem.mem_ack;
  // Fires on the TIMEOUT_CYCLES-th consecutive unacknowledged request cycle.
  assign timeout_c = waiting_c && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      if (waiting_c && !timeout_c && (state_d == state_q)) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      else                                                 wait_cnt_q <= '0;
      if (timeout_c) mem_fault_q <= 1'b1;
    end
  end

  assign mem_fault = mem_fault_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_c = 1'b0;
  assign mem_fault = 1'b0;
`endif

  assign state        = state_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; strobes are checked cycle by cycle.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        update_sreg;
  logic [2:0]  branch_op;
  logic        ir_load;
  logic        sreg_write_en;
  logic        branch_eval;
  logic        rf_write_en;
  logic        pc_write;
  logic [2:0]  state;
  logic        busy;
  logic [31:0] retire_count;
  logic        mem_fault;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_sequencer_if mif ();

  multicycle_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .halt_req      (halt_req),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .update_sreg   (update_sreg),
    .branch_op     (branch_op),
    .mem           (mif),
    .ir_load       (ir_load),
    .sreg_write_en (sreg_write_en),
    .branch_eval   (branch_eval),
    .rf_write_en   (rf_write_en),
    .pc_write      (pc_write),
    .state         (state),
    .busy          (busy),
    .retire_count  (retire_count),
    .mem_fault     (mem_fault)
  );

  always #5 clk = ~clk;

  // Strobe vector order: mem_req mem_we mem_is_data ir_load sreg_write_en branch_eval rf_write_en pc_write
  localparam logic [7:0] ST_NONE  = 8'b0000_0000;
  localparam logic [7:0] ST_FETCH = 8'b1001_0000;
  localparam logic [7:0] ST_FWAIT = 8'b1000_0000;
  localparam logic [7:0] ST_WB    = 8'b0000_0011;
  localparam logic [7:0] ST_LDMEM = 8'b1010_0000;
  localparam logic [7:0] ST_STMEM = 8'b1110_0001;
  localparam logic [7:0] ST_CBZEX = 8'b0000_1101;

  function automatic logic [7:0] strobes();
    return {mif.mem_req, mif.mem_we, mif.mem_is_data, ir_load,
            sreg_write_en, branch_eval, rf_write_en, pc_write};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] exp_state, input logic [7:0] exp_strb);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(exp_state));
    chk({tag, "_strobes"}, 32'(strobes()), 32'(exp_strb));
  endtask

  task automatic set_ctl(input logic rd, input logic wr, input logic rw,
                         input logic us, input logic [2:0] bo);
    mem_read    = rd;
    mem_write   = wr;
    reg_write   = rw;
    update_sreg = us;
    branch_op   = bo;
  endtask

  initial begin
    logic seen_req;
    logic seen_pc;

    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; mif.mem_ack = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tick(); tick();

    // Reset state
    chk_cycle("reset", 3'd0, ST_NONE);
    chk("reset_count", retire_count, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fault", 32'(mem_fault), 32'd0);

    // ADD stream, memory always acks: retire every 4 cycles, back to back
    rst_n = 1'b1; run = 1'b1; mif.mem_ack = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk_cycle("idle_ack_ignored", 3'd0, ST_NONE);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) run = 1'b0;
      chk_cycle($sformatf("add%0d_fetch", k), 3'd1, ST_FETCH);
      chk($sformatf("add%0d_count", k), retire_count, 32'(k));
      tick(); chk_cycle($sformatf("add%0d_decode", k), 3'd2, ST_NONE);
      tick(); chk_cycle($sformatf("add%0d_exec", k), 3'd3, ST_NONE);
      tick(); chk_cycle($sformatf("add%0d_wb", k), 3'd5, ST_WB);
    end
    tick();
    chk_cycle("add_idle", 3'd0, ST_NONE);
    chk("add_count", retire_count, 32'd4);

    // LDUR with a 2-cycle data ack delay; decoder noise during MEMORY is ignored
    run = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    tick(); chk_cycle("ld_fetch", 3'd1, ST_FETCH);
    tick(); chk_cycle("ld_decode", 3'd2, ST_NONE);
    tick(); chk_cycle("ld_exec", 3'd3, ST_NONE);
    tick();
    mif.mem_ack = 1'b0;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    chk_cycle("ld_mem_w1", 3'd4, ST_LDMEM);
    tick(); chk_cycle("ld_mem_w2", 3'd4, ST_LDMEM);
    tick(); mif.mem_ack = 1'b1; chk_cycle("ld_mem_ack", 3'd4, ST_LDMEM);
    tick(); run = 1'b0; chk_cycle("ld_wb", 3'd5, ST_WB);
    tick();
    chk_cycle("ld_idle", 3'd0, ST_NONE);
    chk("ld_count", retire_count, 32'd5);

    // STUR then CBZ back to back
    run = 1'b1;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    tick(); chk_cycle("st_fetch", 3'd1, ST_FETCH);
    tick(); chk_cycle("st_decode", 3'd2, ST_NONE);
    tick(); chk_cycle("st_exec", 3'd3, ST_NONE);
    tick(); chk_cycle("st_mem", 3'd4, ST_STMEM);
    tick();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
    chk_cycle("cbz_fetch", 3'd1, ST_FETCH);
    tick(); chk_cycle("cbz_decode", 3'd2, ST_NONE);
    tick(); run = 1'b0; chk_cycle("cbz_exec", 3'd3, ST_CBZEX);
    tick();
    chk_cycle("cbz_idle", 3'd0, ST_NONE);
    chk("cbz_count", retire_count, 32'd7);

    // halt_req and run both high mid-LDUR: completes, then HALT sticks
    run = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    tick(); chk_cycle("hl_fetch", 3'd1, ST_FETCH);
    tick(); tick();
    tick(); halt_req = 1'b1; chk_cycle("hl_mem", 3'd4, ST_LDMEM);
    tick(); chk_cycle("hl_wb", 3'd5, ST_WB);
    tick();
    chk_cycle("hl_halt", 3'd6, ST_NONE);
    chk("hl_count", retire_count, 32'd8);
    chk("hl_busy", 32'(busy), 32'd0);
    halt_req = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mif.mem_req || state != 3'd6) seen_req = 1'b1;
    end
    chk("hl_sticky_no_req", 32'(seen_req), 32'd0);

    // Reset in the middle of a MEMORY wait aborts the instruction
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b1;
    chk_cycle("rs_out_of_halt", 3'd0, ST_NONE);
    tick(); tick(); tick(); tick();
    mif.mem_ack = 1'b0;
    chk_cycle("rs_mem_wait", 3'd4, ST_LDMEM);
    tick(); rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b0;
    chk_cycle("rs_abort", 3'd0, ST_NONE);
    chk("rs_count", retire_count, 32'd0);

    // Long fetch stall
    run = 1'b1;
    tick(); run = 1'b0;
    seen_pc = 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      tick();
      if (pc_write) seen_pc = 1'b1;
    end
    chk_cycle("to_still_waiting", 3'd1, ST_FWAIT);
    chk("to_no_fault_yet", 32'(mem_fault), 32'd0);
    tick();
    chk_cycle("to_halt", 3'd6, ST_NONE);
    chk("to_fault", 32'(mem_fault), 32'd1);
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pc_write) seen_pc = 1'b1;
    end
    chk_cycle("stall_waiting", 3'd1, ST_FWAIT);
    chk("stall_no_fault", 32'(mem_fault), 32'd0);
`endif
    chk("stall_no_pc_write", 32'(seen_pc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
